// File: rtl/hand_bbox_tracker.sv
// Per-frame bounding-box accumulator for detected hand pixels. The committed box
// is rewritten only in the blanking interval after EOF. Lost hands are debounced over frames.
module hand_bbox_tracker #(
    parameter int H_ACT      = 640,
    parameter int V_ACT      = 480,
    parameter int MIN_PIXELS = 64,
    parameter int MISS_LIMIT = 4,
    parameter int CNT_W      = 20
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iPix_valid,
    input  logic [11:0]      iX,
    input  logic [11:0]      iY,
    input  logic             iHit,
    input  logic             iFreeze,
    output logic [11:0]      hand_x_min,
    output logic [11:0]      hand_x_max,
    output logic [11:0]      hand_y_min,
    output logic [11:0]      hand_y_max,
    output logic             oBox_valid,
    output logic             oUpdate,
    output logic [CNT_W-1:0] oHit_count
);

    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACCUM,
        COMMIT
    } state_e;

    state_e state_q, state_d;

    logic [11:0]      xmin_q, xmin_d, xmax_q, xmax_d;
    logic [11:0]      ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic             apply_q, apply_d;
    logic             upd_acc_q, upd_acc_d;
    logic             upd_drop_q, upd_drop_d;
    logic [11:0]      box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
    logic [11:0]      box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
    logic             box_valid_q, box_valid_d;
    logic             update_q, update_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;

    logic sof, eof, hit;

    assign sof = iPix_valid && (iX == 12'd0) && (iY == 12'd0);
    assign eof = iPix_valid && (iX == 12'(H_ACT - 1)) && (iY == 12'(V_ACT - 1));
    assign hit = iPix_valid && iHit;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (sof) state_d = ACCUM;
            ACCUM:    if (eof && !sof) state_d = COMMIT;
            COMMIT:   state_d = WAIT_SOF;
            default:  state_d = WAIT_SOF;
        endcase
    end

    logic [11:0]       base_xmin, base_xmax, base_ymin, base_ymax;
    logic [CNT_W-1:0]  base_cnt;
    logic              acc_en;
    logic [MISS_W:0]   miss_inc;
    logic              accept;

    always_comb begin
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        cnt_d       = cnt_q;
        miss_d      = miss_q;
        apply_d     = 1'b0;
        upd_acc_d   = 1'b0;
        upd_drop_d  = 1'b0;
        box_x_min_d = box_x_min_q;
        box_x_max_d = box_x_max_q;
        box_y_min_d = box_y_min_q;
        box_y_max_d = box_y_max_q;
        box_valid_d = box_valid_q;
        update_d    = 1'b0;
        hit_count_d = hit_count_q;
        miss_inc    = {1'b0, miss_q} + 1'b1;
        accept      = (cnt_q >= CNT_W'(MIN_PIXELS));
        acc_en      = ((state_q == WAIT_SOF) && sof) || (state_q == ACCUM);

        // An SOF clears the accumulators before its own pixel is folded in.
        base_xmin = sof ? 12'hFFF : xmin_q;
        base_xmax = sof ? 12'h000 : xmax_q;
        base_ymin = sof ? 12'hFFF : ymin_q;
        base_ymax = sof ? 12'h000 : ymax_q;
        base_cnt  = sof ? '0 : cnt_q;

        if (acc_en) begin
            xmin_d = base_xmin;
            xmax_d = base_xmax;
            ymin_d = base_ymin;
            ymax_d = base_ymax;
            cnt_d  = base_cnt;
            if (hit) begin
                if (iX < base_xmin) xmin_d = iX;
                if (iX > base_xmax) xmax_d = iX;
                if (iY < base_ymin) ymin_d = iY;
                if (iY > base_ymax) ymax_d = iY;
                if (base_cnt != '1) cnt_d = base_cnt + 1'b1;
            end
        end

        if (state_q == COMMIT) begin
            apply_d = 1'b1;
            if (!iFreeze) begin
                if (accept) begin
                    upd_acc_d = 1'b1;
                    miss_d    = '0;
                end else begin
                    miss_d = (miss_inc >= (MISS_W + 1)'(MISS_LIMIT)) ?
                             MISS_W'(MISS_LIMIT) : miss_inc[MISS_W-1:0];
                    if ((miss_inc >= (MISS_W + 1)'(MISS_LIMIT)) && box_valid_q)
                        upd_drop_d = 1'b1;
                end
            end
        end

        // Decision is taken in COMMIT and applied one cycle later; the accumulators
        // stay untouched until the next SOF, which blanking keeps beyond this edge.
        if (apply_q) begin
            hit_count_d = cnt_q;
            if (upd_acc_q) begin
                box_x_min_d = xmin_q;
                box_x_max_d = xmax_q;
                box_y_min_d = ymin_q;
                box_y_max_d = ymax_q;
                box_valid_d = 1'b1;
                update_d    = 1'b1;
            end else if (upd_drop_q) begin
                box_valid_d = 1'b0;
                update_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            xmin_q      <= 12'hFFF;
            xmax_q      <= '0;
            ymin_q      <= 12'hFFF;
            ymax_q      <= '0;
            cnt_q       <= '0;
            miss_q      <= '0;
            apply_q     <= 1'b0;
            upd_acc_q   <= 1'b0;
            upd_drop_q  <= 1'b0;
            box_x_min_q <= '0;
            box_x_max_q <= '0;
            box_y_min_q <= '0;
            box_y_max_q <= '0;
            box_valid_q <= 1'b0;
            update_q    <= 1'b0;
            hit_count_q <= '0;
        end else begin
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            cnt_q       <= cnt_d;
            miss_q      <= miss_d;
            apply_q     <= apply_d;
            upd_acc_q   <= upd_acc_d;
            upd_drop_q  <= upd_drop_d;
            box_x_min_q <= box_x_min_d;
            box_x_max_q <= box_x_max_d;
            box_y_min_q <= box_y_min_d;
            box_y_max_q <= box_y_max_d;
            box_valid_q <= box_valid_d;
            update_q    <= update_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign hand_x_min = box_x_min_q;
    assign hand_x_max = box_x_max_q;
    assign hand_y_min = box_y_min_q;
    assign hand_y_max = box_y_max_q;
    assign oBox_valid = box_valid_q;
    assign oUpdate    = update_q;
    assign oHit_count = hit_count_q;

endmodule

// File: tb/tb_hand_bbox_tracker.sv
// Scoreboard bench for hand_bbox_tracker: sparse frames (only SOF, hit pixels and EOF
// are presented), expected commits queued by the driver and popped on each oUpdate.
module tb_hand_bbox_tracker;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iPix_valid = 1'b0;
    logic [11:0] iX = '0;
    logic [11:0] iY = '0;
    logic        iHit = 1'b0;
    logic        iFreeze = 1'b0;
    logic [11:0] hand_x_min, hand_x_max, hand_y_min, hand_y_max;
    logic        oBox_valid, oUpdate;
    logic [19:0] oHit_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [11:0] x0, x1, y0, y1;
        logic        v;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];

    hand_bbox_tracker #(
        .H_ACT(640), .V_ACT(480), .MIN_PIXELS(64), .MISS_LIMIT(4), .CNT_W(20)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iPix_valid(iPix_valid), .iX(iX), .iY(iY),
        .iHit(iHit), .iFreeze(iFreeze),
        .hand_x_min(hand_x_min), .hand_x_max(hand_x_max),
        .hand_y_min(hand_y_min), .hand_y_max(hand_y_max),
        .oBox_valid(oBox_valid), .oUpdate(oUpdate), .oHit_count(oHit_count)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every oUpdate must match the oldest queued commit, on its exact cycle.
    always @(negedge iCLK) begin
        if (oUpdate) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_update: got oUpdate=1, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("upd_cycle",  cyc,            e.cyc);
                check("upd_x_min",  hand_x_min,     e.x0);
                check("upd_x_max",  hand_x_max,     e.x1);
                check("upd_y_min",  hand_y_min,     e.y0);
                check("upd_y_max",  hand_y_max,     e.y1);
                check("upd_valid",  oBox_valid,     e.v);
                check("upd_count",  oHit_count,     e.cnt);
            end
        end
    end

    task automatic pix(input int x, input int y, input logic h);
        @(negedge iCLK);
        iPix_valid = 1'b1;
        iX = 12'(x);
        iY = 12'(y);
        iHit = h;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge iCLK);
            iPix_valid = 1'b0;
            iHit = 1'b0;
        end
    endtask

    task automatic rect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                pix(x, y, 1'b1);
    endtask

    // Called in the same timestep the EOF pixel was driven: it is sampled at edge
    // cyc+1, and the commit becomes visible after edge cyc+3.
    task automatic expect_upd(input int x0, input int x1, input int y0, input int y1,
                              input logic v, input int cnt);
        exp_t e;
        e.cyc = cyc + 3;
        e.x0 = 12'(x0); e.x1 = 12'(x1); e.y0 = 12'(y0); e.y1 = 12'(y1);
        e.v = v; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic status(input string tag, input int x0, input int x1, input int y0,
                          input int y1, input logic v, input int cnt);
        check({tag, "_x_min"}, hand_x_min, 32'(x0));
        check({tag, "_x_max"}, hand_x_max, 32'(x1));
        check({tag, "_y_min"}, hand_y_min, 32'(y0));
        check({tag, "_y_max"}, hand_y_max, 32'(y1));
        check({tag, "_valid"}, oBox_valid, 32'(v));
        check({tag, "_count"}, oHit_count, 32'(cnt));
    endtask

    task automatic box_frame(input int x0, input int x1, input int y0, input int y1);
        pix(0, 0, 1'b0);
        rect(x0, x1, y0, y1);
        pix(639, 479, 1'b0);
    endtask

    task automatic empty_frame();
        pix(0, 0, 1'b0);
        pix(639, 479, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        status("reset", 0, 0, 0, 0, 1'b0, 0);
        check("reset_update", oUpdate, 0);
        iRST = 1'b0;
        idle(2);

        // Single region, 100x100 hits.
        box_frame(100, 199, 50, 149);
        expect_upd(100, 199, 50, 149, 1'b1, 10000);
        idle(8);

        // Threshold: exactly 64 accepts, exactly 63 rejects with the box held.
        box_frame(300, 307, 10, 17);
        expect_upd(300, 307, 10, 17, 1'b1, 64);
        idle(8);
        pix(0, 0, 1'b0);
        rect(300, 307, 10, 16);
        rect(300, 306, 17, 17);
        pix(639, 479, 1'b0);
        idle(8);
        status("reject63", 300, 307, 10, 17, 1'b1, 63);

        // Loss debounce: re-accept to clear misses, then empty frames.
        box_frame(300, 307, 10, 17);
        expect_upd(300, 307, 10, 17, 1'b1, 64);
        idle(8);
        for (int f = 1; f <= 3; f++) begin
            empty_frame();
            idle(8);
            status("miss", 300, 307, 10, 17, 1'b1, 0);
        end
        empty_frame();
        expect_upd(300, 307, 10, 17, 1'b0, 0);
        idle(8);
        empty_frame();
        idle(8);
        status("miss5", 300, 307, 10, 17, 1'b0, 0);

        // Freeze: box A, one miss, frozen frame B must neither update nor touch misses.
        box_frame(20, 27, 30, 37);
        expect_upd(20, 27, 30, 37, 1'b1, 64);
        idle(8);
        empty_frame();
        idle(8);
        iFreeze = 1'b1;
        box_frame(400, 409, 400, 409);
        idle(8);
        iFreeze = 1'b0;
        status("freeze", 20, 27, 30, 37, 1'b1, 100);
        empty_frame();
        idle(8);
        empty_frame();
        idle(8);
        status("frz_miss3", 20, 27, 30, 37, 1'b1, 0);
        empty_frame();
        expect_upd(20, 27, 30, 37, 1'b0, 0);
        idle(8);

        // Partial frame after reset is discarded; next full frame commits.
        iRST = 1'b1;
        idle(3);
        status("reset2", 0, 0, 0, 0, 1'b0, 0);
        pix(320, 240, 1'b1);
        iRST = 1'b0;
        rect(320, 327, 241, 247);
        pix(639, 479, 1'b1);
        idle(8);
        status("partial", 0, 0, 0, 0, 1'b0, 0);
        box_frame(50, 57, 60, 67);
        expect_upd(50, 57, 60, 67, 1'b1, 64);
        idle(8);

        // Corner pixels are SOF and EOF themselves; 62 interior hits reach threshold.
        pix(0, 0, 1'b1);
        rect(300, 361, 200, 200);
        pix(639, 479, 1'b1);
        expect_upd(0, 639, 0, 479, 1'b1, 64);
        idle(10);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_update: got %0d commits outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
